// File: rtl/rv_instr_encoder_if.sv
// rv_instr_encoder_if: request/response bundle for rv_instr_encoder.
//   Request side : in_valid_i/in_ready_o handshake plus field inputs
//                  (cls_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i).
//   Response side: out_valid_o/out_ready_i handshake, instr_o, err_o, count_o.
//   With RV_INSTR_ENCODER_ADDR_GEN_EN defined, also addr_o and mem_we_o.
// Signal suffixes are from the encoder's point of view.
// master = request producer / word consumer, slave = the encoder.
interface rv_instr_encoder_if #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          in_valid_i;
  logic          in_ready_o;
  logic [2:0]    cls_i;
  logic [4:0]    rd_i;
  logic [4:0]    rs1_i;
  logic [4:0]    rs2_i;
  logic [2:0]    funct3_i;
  logic [6:0]    funct7_i;
  logic [31:0]   imm_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [31:0]   instr_o;
  logic          err_o;
  logic [CW-1:0] count_o;

`ifdef RV_INSTR_ENCODER_ADDR_GEN_EN
  logic [ADDR_WIDTH-1:0] addr_o;
  logic                  mem_we_o;

  modport master (
    output in_valid_i, cls_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, out_ready_i,
    input  in_ready_o, out_valid_o, instr_o, err_o, count_o, addr_o, mem_we_o
  );
  modport slave (
    input  in_valid_i, cls_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, out_ready_i,
    output in_ready_o, out_valid_o, instr_o, err_o, count_o, addr_o, mem_we_o
  );
`else
  // ADDR_WIDTH only sizes the address port; keep it referenced.
  logic unused_aw;
  assign unused_aw = ADDR_WIDTH[0];

  modport master (
    output in_valid_i, cls_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, out_ready_i,
    input  in_ready_o, out_valid_o, instr_o, err_o, count_o
  );
  modport slave (
    input  in_valid_i, cls_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, out_ready_i,
    output in_ready_o, out_valid_o, instr_o, err_o, count_o
  );
`endif
endinterface

// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: builds RV32I instruction words from field-level requests.
// Each accepted request is encoded combinationally and written into a
// DEPTH-entry FIFO; words leave through the out_valid/out_ready handshake
// with an encode-error sideband bit.
// Ports:
//   clk_i    clock, rising edge
//   rst_n_i  synchronous active-low reset
//   bus_if   rv_instr_encoder_if.slave (request fields, handshakes, instr/err/count)
// Optional: define RV_INSTR_ENCODER_ADDR_GEN_EN to add addr_o (byte address of
// the head word, starts at BASE_ADDR, +4 per pop) and mem_we_o (= pop).
module rv_instr_encoder #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  rv_instr_encoder_if.slave   bus_if
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    C_LOAD = 3'd0, C_STORE = 3'd1, C_OP  = 3'd2, C_BRANCH = 3'd3,
    C_OPIMM = 3'd4, C_JAL  = 3'd5, C_JALR = 3'd6, C_LUI   = 3'd7
  } cls_e;

  // ---------------- encoder ----------------
  cls_e        cls;
  logic [31:0] imm;
  logic        fit12, fit13, fit21;
  logic [31:0] enc_word;
  logic        enc_err;

  assign cls = cls_e'(bus_if.cls_i);
  assign imm = bus_if.imm_i;

  // Sign-fits-N: every bit from N-1 upward equals the sign bit.
  assign fit12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fit13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fit21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    unique case (cls)
      C_LOAD: begin
        enc_word = {imm[11:0], bus_if.rs1_i, bus_if.funct3_i, bus_if.rd_i, 7'b0000011};
        enc_err  = !fit12;
      end
      C_OPIMM: begin
        enc_word = {imm[11:0], bus_if.rs1_i, bus_if.funct3_i, bus_if.rd_i, 7'b0010011};
        enc_err  = !fit12;
      end
      C_JALR: begin
        enc_word = {imm[11:0], bus_if.rs1_i, 3'b000, bus_if.rd_i, 7'b1100111};
        enc_err  = !fit12;
      end
      C_STORE: begin
        enc_word = {imm[11:5], bus_if.rs2_i, bus_if.rs1_i, bus_if.funct3_i,
                    imm[4:0], 7'b0100011};
        enc_err  = !fit12;
      end
      C_OP: begin
        enc_word = {bus_if.funct7_i, bus_if.rs2_i, bus_if.rs1_i, bus_if.funct3_i,
                    bus_if.rd_i, 7'b0110011};
      end
      C_BRANCH: begin
        enc_word = {imm[12], imm[10:5], bus_if.rs2_i, bus_if.rs1_i, bus_if.funct3_i,
                    imm[4:1], imm[11], 7'b1100011};
        enc_err  = !fit13 || imm[0];
      end
      C_JAL: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus_if.rd_i, 7'b1101111};
        enc_err  = !fit21 || imm[0];
      end
      C_LUI: begin
        enc_word = {imm[31:12], bus_if.rd_i, 7'b0110111};
      end
      default: ;
    endcase
  end

  // ---------------- FIFO ----------------
  // Entry layout: {err, instr}.
  logic [DEPTH-1:0][32:0] mem_q;
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   rdy_q;
  logic                   push, pop;

  assign push = bus_if.in_valid_i && rdy_q;
  assign pop  = (cnt_q != '0) && bus_if.out_ready_i;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Ready is registered from the next count, so a pop while full only
  // reopens the input one cycle later. DEPTH is a power of two, so the
  // pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {enc_err, enc_word};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d != CW'(DEPTH));
    end
  end

  assign bus_if.in_ready_o  = rdy_q;
  assign bus_if.out_valid_o = (cnt_q != '0);
  assign bus_if.instr_o     = mem_q[rd_ptr_q][31:0];
  assign bus_if.err_o       = mem_q[rd_ptr_q][32];
  assign bus_if.count_o     = cnt_q;

  // ---------------- optional address generator ----------------
`ifdef RV_INSTR_ENCODER_ADDR_GEN_EN
  logic [ADDR_WIDTH-1:0] addr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)  addr_q <= ADDR_WIDTH'(BASE_ADDR);
    else if (pop)  addr_q <= addr_q + ADDR_WIDTH'(4);
  end

  assign bus_if.addr_o   = addr_q;
  assign bus_if.mem_we_o = pop;
`else
  logic unused_cfg;
  assign unused_cfg = ADDR_WIDTH[0] ^ BASE_ADDR[0];
`endif

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Scoreboard bench for rv_instr_encoder: expected {err,instr} pairs are
// queued as each request is accepted and compared as words are popped.
module tb_rv_instr_encoder;
  localparam int DEPTH = 4;
  localparam int AW    = 8;
  localparam int BASE  = 0;

  localparam logic [2:0] LOAD = 3'd0, STORE = 3'd1, OP = 3'd2, BRANCH = 3'd3,
                         OPIMM = 3'd4, JAL = 3'd5, JALR = 3'd6, LUI = 3'd7;

  typedef struct packed {
    logic [2:0]  cls;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_i;
    logic        exp_e;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv_instr_encoder_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) bus();

  rv_instr_encoder #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus_if (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;
  logic [32:0] sbq[$];

  task automatic drive(input req_t r);
    bus.cls_i = r.cls; bus.rd_i = r.rd; bus.rs1_i = r.rs1; bus.rs2_i = r.rs2;
    bus.funct3_i = r.f3; bus.funct7_i = r.f7; bus.imm_i = r.imm;
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input req_t r);
    int g = 0;
    drive(r);
    bus.in_valid_i = 1'b1;
    while (bus.in_ready_o !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    tests_run++;
    if (g == 20) begin
      tests_failed++;
      $display("FAIL send_timeout in_ready=%b required=1", bus.in_ready_o);
      bus.in_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    sbq.push_back({r.exp_e, r.exp_i});
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  // Waits for a head word, samples it, pops it. No checking here.
  task automatic pop(output logic [31:0] oi, output logic oe, output bit ok);
    int g = 0;
    ok = 1'b0;
    while (bus.out_valid_o !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    oi = bus.instr_o;
    oe = bus.err_o;
    if (g < 20) begin
      ok = 1'b1;
      bus.out_ready_i = 1'b1;
      @(negedge clk);
      bus.out_ready_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++; if (bus.count_o !== 3'd0) begin tests_failed++; $display("FAIL rst_count got=%0d req=0", bus.count_o); end
    tests_run++; if (bus.out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid got=%b req=0", bus.out_valid_o); end
    tests_run++; if (bus.instr_o !== 32'h0 || bus.err_o !== 1'b0) begin tests_failed++; $display("FAIL rst_head got=%b/%h req=0/0", bus.err_o, bus.instr_o); end
    tests_run++; if (bus.in_ready_o !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready_low got=%b req=0", bus.in_ready_o); end
`ifdef RV_INSTR_ENCODER_ADDR_GEN_EN
    tests_run++; if (bus.addr_o !== AW'(BASE)) begin tests_failed++; $display("FAIL rst_addr got=%h req=%h", bus.addr_o, AW'(BASE)); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (bus.in_ready_o !== 1'b1) begin tests_failed++; $display("FAIL rst_in_ready_rel got=%b req=1", bus.in_ready_o); end
  endtask

  task automatic test_opimm();
    req_t r = '{OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0};
    logic [31:0] oi; logic oe; bit ok; logic [32:0] ex;
    drive(r);
    bus.in_valid_i = 1'b1;
    tests_run++; if (bus.out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL opimm_no_bypass got=%b req=0", bus.out_valid_o); end
    @(posedge clk);
    sbq.push_back({r.exp_e, r.exp_i});
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    tests_run++; if (bus.out_valid_o !== 1'b1 || bus.count_o !== 3'd1) begin tests_failed++; $display("FAIL opimm_latency got=%b/%0d req=1/1", bus.out_valid_o, bus.count_o); end
    pop(oi, oe, ok); ex = sbq.pop_front();
    tests_run++; if (!ok || {oe, oi} !== ex) begin tests_failed++; $display("FAIL opimm_word got=%b/%h req=%b/%h", oe, oi, ex[32], ex[31:0]); end
  endtask

  task automatic test_back_to_back();
    req_t tbl[3];
    logic [31:0] oi; logic oe; bit ok; logic [32:0] ex;
    tbl[0] = '{LOAD,  5'd2, 5'd1, 5'd0, 3'd2, 7'd0, 32'd8,  32'h0080A103, 1'b0};
    tbl[1] = '{STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd12, 32'h0020A623, 1'b0};
    tbl[2] = '{OP,    5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,  32'h002081B3, 1'b0};
    foreach (tbl[k]) send(tbl[k]);
    tests_run++; if (bus.count_o !== 3'd3) begin tests_failed++; $display("FAIL b2b_count got=%0d req=3", bus.count_o); end
    for (int k = 0; k < 3; k++) begin
      pop(oi, oe, ok); ex = sbq.pop_front();
      tests_run++; if (!ok || {oe, oi} !== ex) begin tests_failed++; $display("FAIL b2b_word%0d got=%b/%h req=%b/%h", k, oe, oi, ex[32], ex[31:0]); end
    end
  endtask

  task automatic test_control_flow();
    req_t tbl[4];
    logic [31:0] oi; logic oe; bit ok; logic [32:0] ex;
    tbl[0] = '{BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0};
    tbl[1] = '{JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8,        32'h008000EF, 1'b0};
    tbl[2] = '{LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0};
    tbl[3] = '{JALR,   5'd1, 5'd2, 5'd0, 3'd7, 7'd0, 32'd0,        32'h000100E7, 1'b0};
    foreach (tbl[k]) begin
      send(tbl[k]);
      pop(oi, oe, ok); ex = sbq.pop_front();
      tests_run++; if (!ok || {oe, oi} !== ex) begin tests_failed++; $display("FAIL ctrl_word%0d got=%b/%h req=%b/%h", k, oe, oi, ex[32], ex[31:0]); end
    end
  endtask

  task automatic test_err_flags();
    req_t tbl[9];
    logic [31:0] oi; logic oe; bit ok; logic [32:0] ex;
    tbl[0] = '{OPIMM,  5'd0, 5'd0, 5'd0, 3'd0, 7'd0,  32'd2048,     32'h80000013, 1'b1};
    tbl[1] = '{BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,  32'd6,        32'h00000363, 1'b0};
    tbl[2] = '{BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,  32'd5,        32'h00000263, 1'b1};
    tbl[3] = '{STORE,  5'd0, 5'd0, 5'd0, 3'd0, 7'd0,  32'hFFFFF7FF, 32'h7E000FA3, 1'b1};
    tbl[4] = '{JAL,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0,  32'h00100000, 32'h8000006F, 1'b1};
    tbl[5] = '{JAL,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0,  32'hFFF00000, 32'h8000006F, 1'b0};
    tbl[6] = '{JAL,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0,  32'd3,        32'h0020006F, 1'b1};
    tbl[7] = '{OP,     5'd0, 5'd0, 5'd0, 3'd0, 7'h20, 32'hFFFFFFFF, 32'h40000033, 1'b0};
    tbl[8] = '{LUI,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0,  32'hFFFFF123, 32'hFFFFF037, 1'b0};
    foreach (tbl[k]) begin
      send(tbl[k]);
      pop(oi, oe, ok); ex = sbq.pop_front();
      tests_run++; if (!ok || {oe, oi} !== ex) begin tests_failed++; $display("FAIL err_word%0d got=%b/%h req=%b/%h", k, oe, oi, ex[32], ex[31:0]); end
    end
  endtask

  task automatic test_backpressure();
    req_t r;
    logic [31:0] oi; logic oe; bit ok; logic [32:0] ex;
    bus.out_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      r = '{LUI, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k) << 12,
            (32'(k) << 12) | (32'(k) << 7) | 32'h37, 1'b0};
      if (k < 4) send(r);
    end
    tests_run++; if (bus.count_o !== 3'd4) begin tests_failed++; $display("FAIL bp_full_count got=%0d req=4", bus.count_o); end
    tests_run++; if (bus.in_ready_o !== 1'b0) begin tests_failed++; $display("FAIL bp_full_ready got=%b req=0", bus.in_ready_o); end
    // 5th request waits while one word is popped.
    drive(r);
    bus.in_valid_i  = 1'b1;
    bus.out_ready_i = 1'b1;
    oi = bus.instr_o; oe = bus.err_o;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    ex = sbq.pop_front();
    tests_run++; if ({oe, oi} !== ex) begin tests_failed++; $display("FAIL bp_pop_word got=%b/%h req=%b/%h", oe, oi, ex[32], ex[31:0]); end
    tests_run++; if (bus.count_o !== 3'd3) begin tests_failed++; $display("FAIL bp_after_pop_count got=%0d req=3", bus.count_o); end
    tests_run++; if (bus.in_ready_o !== 1'b1) begin tests_failed++; $display("FAIL bp_reopen_ready got=%b req=1", bus.in_ready_o); end
    @(posedge clk);
    sbq.push_back({r.exp_e, r.exp_i});
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    tests_run++; if (bus.count_o !== 3'd4) begin tests_failed++; $display("FAIL bp_fifth_count got=%0d req=4", bus.count_o); end
    for (int k = 0; k < 4; k++) begin
      pop(oi, oe, ok); ex = sbq.pop_front();
      tests_run++; if (!ok || {oe, oi} !== ex) begin tests_failed++; $display("FAIL bp_word%0d got=%b/%h req=%b/%h", k, oe, oi, ex[32], ex[31:0]); end
    end
  endtask

  task automatic test_reset_mid();
    req_t tbl[3];
    logic [31:0] oi; logic oe; bit ok; logic [32:0] ex;
    tbl[0] = '{LOAD, 5'd4, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0,  32'h00008203, 1'b0};
    tbl[1] = '{LOAD, 5'd5, 5'd1, 5'd0, 3'd0, 7'd0, 32'd4,  32'h00408283, 1'b0};
    tbl[2] = '{LOAD, 5'd6, 5'd1, 5'd0, 3'd0, 7'd0, 32'd16, 32'h01008303, 1'b0};
    foreach (tbl[k]) send(tbl[k]);
    tests_run++; if (bus.count_o !== 3'd3) begin tests_failed++; $display("FAIL rm_pre_count got=%0d req=3", bus.count_o); end
    // Reset with a push and a pop pending in the same cycle.
    drive(tbl[0]);
    bus.in_valid_i = 1'b1; bus.out_ready_i = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
    sbq.delete();
    tests_run++; if (bus.count_o !== 3'd0 || bus.out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL rm_flush got=%0d/%b req=0/0", bus.count_o, bus.out_valid_o); end
    tests_run++; if (bus.in_ready_o !== 1'b0 || bus.instr_o !== 32'h0) begin tests_failed++; $display("FAIL rm_ready_head got=%b/%h req=0/0", bus.in_ready_o, bus.instr_o); end
    rst_n = 1'b1;
    @(negedge clk);
`ifdef RV_INSTR_ENCODER_ADDR_GEN_EN
    tests_run++; if (bus.addr_o !== AW'(BASE)) begin tests_failed++; $display("FAIL rm_addr_base got=%h req=%h", bus.addr_o, AW'(BASE)); end
`endif
    foreach (tbl[k]) send(tbl[k]);
    for (int k = 0; k < 3; k++) begin
`ifdef RV_INSTR_ENCODER_ADDR_GEN_EN
      tests_run++; if (bus.addr_o !== AW'(BASE + 4 * k)) begin tests_failed++; $display("FAIL rm_addr%0d got=%h req=%h", k, bus.addr_o, AW'(BASE + 4 * k)); end
`endif
      pop(oi, oe, ok); ex = sbq.pop_front();
      tests_run++; if (!ok || {oe, oi} !== ex) begin tests_failed++; $display("FAIL rm_word%0d got=%b/%h req=%b/%h", k, oe, oi, ex[32], ex[31:0]); end
    end
  endtask

  initial begin
    bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
    bus.cls_i = '0; bus.rd_i = '0; bus.rs1_i = '0; bus.rs2_i = '0;
    bus.funct3_i = '0; bus.funct7_i = '0; bus.imm_i = '0;
    test_reset();
    test_opimm();
    test_back_to_back();
    test_control_flow();
    test_err_flags();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute time bound in case a task stalls unexpectedly.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running req=finished");
    $fatal(1, "timeout");
  end
endmodule
